// File: rtl/ccd_timing_gen.sv
// ccd_timing_gen: multi-channel programmable clock/strobe generator with shadowed config and stretched reset
module ccd_timing_gen #(
  parameter int NCH = 4,
  parameter int CW = 8,
  parameter int RST_CYC = 1048575,
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           enable,
  input  logic           resync,
  input  logic           cfg_wr,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [CW-1:0]  cfg_period,
  input  logic [CW-1:0]  cfg_rise,
  input  logic [CW-1:0]  cfg_fall,
  output logic [NCH-1:0] ch_out,
  output logic [NCH-1:0] wrap,
  output logic [NCH-1:0] cfg_pending,
  output logic           rst_out
);
  localparam int RW = $clog2(RST_CYC + 1);
  localparam logic [RW-1:0] RST_MAX = RW'(RST_CYC);
  logic [NCH-1:0][CW-1:0] cnt_q, cnt_d, act_p_q, act_r_q, act_f_q, sh_p_q, sh_r_q, sh_f_q;
  logic [NCH-1:0] pend_q, ch_out_q, wrap_q, wr_hit, apply, restart, win;
  logic [RW-1:0] rcnt_q;
  logic rst_out_q;
  assign ch_out = ch_out_q;
  assign wrap = wrap_q;
  assign cfg_pending = pend_q;
  assign rst_out = rst_out_q;
  // Per-channel write decode, config-apply points, next count and window comparison
  always_comb begin
    wr_hit = '0;
    apply = '0;
    restart = '0;
    win = '0;
    cnt_d = '0;
    for (int i = 0; i < NCH; i++) begin
      wr_hit[i] = cfg_wr && cfg_ch == CHW'(i);
      restart[i] = !enable || resync || cnt_q[i] == act_p_q[i];
      apply[i] = pend_q[i] && restart[i];
      cnt_d[i] = restart[i] ? '0 : cnt_q[i] + 1'b1;
      win[i] = (act_r_q[i] < act_f_q[i]) ? (cnt_q[i] >= act_r_q[i] && cnt_q[i] < act_f_q[i]) :
               (act_r_q[i] > act_f_q[i]) ? (cnt_q[i] >= act_r_q[i] || cnt_q[i] < act_f_q[i]) : 1'b0;
    end
  end
  // Channel state: counters, active/shadow configs, pending flags and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      act_p_q <= '0;
      act_r_q <= '0;
      act_f_q <= '0;
      sh_p_q <= '0;
      sh_r_q <= '0;
      sh_f_q <= '0;
      pend_q <= '0;
      ch_out_q <= '0;
      wrap_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= cnt_d[i];
        if (apply[i]) begin
          act_p_q[i] <= sh_p_q[i];
          act_r_q[i] <= sh_r_q[i];
          act_f_q[i] <= sh_f_q[i];
        end
        if (wr_hit[i]) begin
          sh_p_q[i] <= cfg_period;
          sh_r_q[i] <= cfg_rise;
          sh_f_q[i] <= cfg_fall;
        end
        pend_q[i] <= wr_hit[i] || (pend_q[i] && !apply[i]);
        ch_out_q[i] <= enable && act_p_q[i] != '0 && win[i];
        wrap_q[i] <= enable && act_p_q[i] != '0 && cnt_q[i] == '0;
      end
    end
  end
  // Reset stretcher: high during rst and for RST_CYC cycles after, counter saturates
  always_ff @(posedge clk) begin
    if (rst) begin
      rcnt_q <= '0;
      rst_out_q <= 1'b1;
    end else begin
      rcnt_q <= (rcnt_q < RST_MAX) ? rcnt_q + 1'b1 : rcnt_q;
      rst_out_q <= rcnt_q < RST_MAX;
    end
  end
endmodule

// File: tb/tb_ccd_timing_gen.sv
// tb_ccd_timing_gen: directed self-checking bench for ccd_timing_gen
module tb_ccd_timing_gen;
  logic clk, rst, enable, resync, cfg_wr;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_period, cfg_rise, cfg_fall;
  logic [2:0] ch_out, wrap, cfg_pending;
  logic rst_out;
  int checks = 0;
  int errors = 0;
  int hi;

  ccd_timing_gen #(.NCH(3), .CW(8), .RST_CYC(16)) dut (
    .clk(clk), .rst(rst), .enable(enable), .resync(resync), .cfg_wr(cfg_wr),
    .cfg_ch(cfg_ch), .cfg_period(cfg_period), .cfg_rise(cfg_rise), .cfg_fall(cfg_fall),
    .ch_out(ch_out), .wrap(wrap), .cfg_pending(cfg_pending), .rst_out(rst_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] ch, input logic [7:0] p, input logic [7:0] r, input logic [7:0] f);
    cfg_wr = 1'b1;
    cfg_ch = ch;
    cfg_period = p;
    cfg_rise = r;
    cfg_fall = f;
    step(1);
    cfg_wr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; resync = 1'b0; cfg_wr = 1'b0;
    cfg_ch = '0; cfg_period = '0; cfg_rise = '0; cfg_fall = '0;
    // reset held 3 cycles, then stretch with a config write during the stretch
    step(3);
    chk("rst_ch_out", ch_out, 0);
    chk("rst_wrap", wrap, 0);
    chk("rst_pending", cfg_pending, 0);
    chk("rst_out_hi", rst_out, 1);
    hi = 3;
    rst = 1'b0;
    wr(2'd0, 8'd39, 8'd20, 8'd40);
    if (rst_out) hi++;
    chk("wr_in_stretch_pend", cfg_pending, 3'b001);
    step(1);
    if (rst_out) hi++;
    chk("apply_while_disabled", cfg_pending, 3'b000);
    for (int k = 0; k < 38; k++) begin
      step(1);
      if (rst_out) hi++;
    end
    chk("rst_stretch_len", hi, 19);
    chk("rst_out_lo", rst_out, 0);
    // ch0 20 low / 20 high, wrap every 40
    enable = 1'b1;
    for (int k = 0; k < 80; k++) begin
      step(1);
      chk("b_out", ch_out, {2'b00, (k % 40) >= 20});
      chk("b_wrap", wrap, {2'b00, (k % 40) == 0});
    end
    // ch1/ch2 configured, out-of-range write ignored, then resync aligns all
    wr(2'd1, 8'd39, 8'd1, 8'd9);
    wr(2'd2, 8'd119, 8'd60, 8'd120);
    step(2);
    chk("c_pend_applied", cfg_pending, 3'b000);
    wr(2'd3, 8'd5, 8'd1, 8'd2);
    chk("c_oob_ignored", cfg_pending, 3'b000);
    resync = 1'b1;
    step(1);
    resync = 1'b0;
    for (int k = 0; k < 240; k++) begin
      step(1);
      chk("c_out", ch_out, {(k % 120) >= 60, (k % 40) >= 1 && (k % 40) < 9, (k % 40) >= 20});
      chk("c_wrap", wrap, {(k % 120) == 0, (k % 40) == 0, (k % 40) == 0});
    end
    // wrapping window R>F, then R==F constant low
    wr(2'd0, 8'd9, 8'd8, 8'd2);
    chk("d_pend", cfg_pending, 3'b001);
    resync = 1'b1;
    step(1);
    resync = 1'b0;
    chk("d_resync_apply", cfg_pending, 3'b000);
    for (int k = 0; k < 30; k++) begin
      step(1);
      chk("d_out", ch_out[0], (k % 10) >= 8 || (k % 10) < 2);
      chk("d_wrap", wrap[0], (k % 10) == 0);
    end
    wr(2'd0, 8'd9, 8'd5, 8'd5);
    step(12);
    chk("d_eq_pend", cfg_pending, 3'b000);
    for (int k = 0; k < 20; k++) begin
      step(1);
      chk("d_eq_low", ch_out[0], 0);
    end
    // mid-period write pends until wrap, then 20-cycle period
    wr(2'd0, 8'd39, 8'd20, 8'd40);
    resync = 1'b1;
    step(1);
    resync = 1'b0;
    step(10);
    wr(2'd0, 8'd19, 8'd10, 8'd20);
    chk("e_pend", cfg_pending[0], 1);
    for (int c = 11; c < 40; c++) begin
      step(1);
      chk("e_old_out", ch_out[0], c >= 20);
      chk("e_old_pend", cfg_pending[0], c != 39);
    end
    for (int k = 0; k < 40; k++) begin
      step(1);
      chk("e_new_out", ch_out[0], (k % 20) >= 10);
      chk("e_new_wrap", wrap[0], (k % 20) == 0);
    end
    // write coinciding with wrap: previous shadow applied, pending stays set
    wr(2'd0, 8'd29, 8'd0, 8'd15);
    step(18);
    chk("e_pend2", cfg_pending[0], 1);
    wr(2'd0, 8'd9, 8'd0, 8'd5);
    chk("e_coinc_out", ch_out[0], 1);
    chk("e_coinc_pend", cfg_pending[0], 1);
    for (int c = 0; c < 30; c++) begin
      step(1);
      chk("e_p29_out", ch_out[0], c < 15);
      chk("e_p29_pend", cfg_pending[0], c != 29);
      chk("e_p29_wrap", wrap[0], c == 0);
    end
    for (int c = 0; c < 10; c++) begin
      step(1);
      chk("e_p9_out", ch_out[0], c < 5);
      chk("e_p9_wrap", wrap[0], c == 0);
    end
    // enable dropped mid-period, config written while disabled, restart from 0
    step(5);
    chk("f_pre_drop", ch_out[0], 1);
    enable = 1'b0;
    step(1);
    chk("f_drop_out", ch_out, 0);
    chk("f_drop_wrap", wrap, 0);
    wr(2'd0, 8'd7, 8'd2, 8'd6);
    chk("f_wr_pend", cfg_pending, 3'b001);
    step(1);
    chk("f_applied", cfg_pending, 3'b000);
    enable = 1'b1;
    for (int k = 0; k < 16; k++) begin
      step(1);
      chk("f_out", ch_out, {1'b0, k >= 1 && k < 9, (k % 8) >= 2 && (k % 8) < 6});
      chk("f_wrap", wrap, {k == 0, k == 0, (k % 8) == 0});
    end
    // reset mid-stream discards pending and active configs
    wr(2'd0, 8'd3, 8'd1, 8'd2);
    chk("g_pend", cfg_pending, 3'b001);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("g_rst_out", ch_out, 0);
    chk("g_rst_wrap", wrap, 0);
    chk("g_rst_pend", cfg_pending, 0);
    chk("g_rst_stretch", rst_out, 1);
    for (int k = 0; k < 10; k++) begin
      step(1);
      chk("g_disabled_out", ch_out, 0);
      chk("g_disabled_wrap", wrap, 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ccd_timing_gen.md
CCD_TIMING_GEN -- requirements
Module: ccd_timing_gen

Interface
REQ-001 SHALL have parameter NCH, default 4: number of independent timing channels (1..16).
REQ-002 SHALL have parameter CW, default 8: width of the per-channel counter and config fields.
REQ-003 SHALL have parameter RST_CYC, default 1048575: reset-stretch length in clk cycles (>=1).
REQ-004 SHALL have port clk, input, 1: single clock; all logic on the rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port enable, input, 1: run/hold for all channels.
REQ-007 SHALL have port resync, input, 1: one-cycle pulse that restarts all counters together.
REQ-008 SHALL have port cfg_wr, input, 1: config write strobe.
REQ-009 SHALL have port cfg_ch, input, max(1,clog2(NCH)): target channel.
REQ-010 SHALL have ports cfg_period, cfg_rise and cfg_fall, input, CW each: period P, window start R, window end F.
REQ-011 SHALL have port ch_out, output, NCH: generated clock or strobe, one bit per channel.
REQ-012 SHALL have port wrap, output, NCH: per-channel period-start pulse.
REQ-013 SHALL have port cfg_pending, output, NCH: a written config is waiting to take effect.
REQ-014 SHALL have port rst_out, output, 1: stretched reset for downstream logic, active-high.

Function
REQ-015 SHALL give each channel an active config (P,R,F), a shadow config, a pending flag and a CW-bit counter cnt.
REQ-016 SHALL, on a cfg_wr with cfg_ch<NCH, write the shadow config of that channel and set its pending flag; cfg_wr with cfg_ch>=NCH SHALL be ignored.
REQ-017 SHALL let the last write win when a channel is written again while pending.
REQ-018 SHALL treat P=0 as channel disabled: cnt held at 0, ch_out low, wrap low.
REQ-019 SHALL, with P>0 and enable=1, count cnt 0,1,...,P,0; the period is P+1 cycles.
REQ-020 SHALL copy shadow to active and clear pending when cnt==P (wrap), so the new config applies from the next cnt=0.
REQ-021 SHALL also apply a pending config on any cycle with enable=0, so that while enable=0 any written config is active by the following cycle.
REQ-022 SHALL, when a cfg_wr to a channel coincides with its wrap, apply the previously pending shadow at this wrap, capture the new data into shadow, and leave pending set.
REQ-023 SHALL, on resync=1 with enable=1, force every cnt to 0 on the next cycle and apply all pending configs.
REQ-024 SHALL hold all cnt at 0 while enable=0, with ch_out=0 and wrap=0 one cycle later.
REQ-025 SHALL compute the window from the value of cnt: R==F gives low; R<F gives high for R<=cnt<F; R>F gives high for cnt>=R or cnt<F (window wraps the period).
REQ-026 SHALL compare R and F greater than P literally, with no clamping.
REQ-027 SHALL register ch_out: ch_out at cycle t+1 reflects cnt at cycle t, one cycle of latency.
REQ-028 SHALL register wrap: wrap[i] is high for exactly one cycle, the cycle after cnt==0 for channel i, aligned with ch_out.
REQ-029 SHALL make all channels with equal P that started from the same resync or enable edge phase-aligned.
REQ-030 SHALL drive rst_out high while rst=1 and for exactly RST_CYC cycles after rst deasserts, then low; its counter SHALL saturate and is unaffected by enable or resync.
REQ-031 SHALL make ch_out free of combinational paths from any input.

Reset
REQ-032 SHALL, with rst=1, clear all counters, active and shadow configs, pending flags, ch_out, wrap and the stretch counter, and drive rst_out=1.
REQ-033 SHALL, on rst asserted mid-operation, take all outputs to reset values on the next clock edge; configs written before rst SHALL be discarded.
REQ-034 SHALL accept cfg_wr normally while rst_out=1 and rst=0.

Verification
REQ-035 SHALL cover this scenario: clk 200 MHz, ch0 write P=39, R=20, F=40, enable=1 -> ch0 is 20 cycles low then 20 high, 5 MHz, with wrap every 40 cycles.
REQ-036 SHALL cover this scenario: ch1 P=39, R=1, F=9, plus ch2 P=119, R=60, F=120, one resync -> ch1 high for counts 1..8, and ch2 has period 120 with 60 low/60 high, with ch1 and ch2 wrap coincident every 120 cycles.
REQ-037 SHALL cover this scenario: ch0 P=9, R=8, F=2 -> ch0 high for counts 8,9,0,1 and low for counts 2..7; R=F=5 -> ch0 constant low.
REQ-038 SHALL cover this scenario: ch0 running with P=39 and a mid-period write of P=19 -> pending=1 until the wrap, old period completes, new 20-cycle period from the next cnt=0; a write coinciding with the wrap -> pending stays 1.
REQ-039 SHALL cover this scenario: RST_CYC=16, pulse rst for 3 cycles -> rst_out is high during rst plus 16 cycles; rst reasserted mid-stream -> ch_out=0 and pending=0 next cycle.
REQ-040 SHALL cover this scenario: enable dropped mid-period -> outputs low after 1 cycle; enable raised -> counting restarts from cnt=0 and a cfg written while enable=0 is already active.
